aes_req_arbiter: RTL and testbench
==================================

# aes_req_arbiter

Round-robin arbiter and sequencer that shares one AES cipher unit between NREQ requesters. It sits between the requester ports and the cipher core's control/data boundary. It issues one block at a time by gating the core's key-ready flag and presenting the winning requester's data and direction while the core signals input-ready. It captures the result when the core returns to its input state, then returns the result with the requester ID on a single response port.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 128: block width
- TO_CYCLES, 31: run-timeout limit; used only with the timeout feature
- CLK  in  1  clock, rising edge
- CLR_N  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request pending; requester holds it until accepted
- req_ready  out  NREQ  one-hot accept strobe
- req_enc_dec  in  NREQ  1 = encrypt, 0 = decrypt
- req_data  in  NREQ*DW  block per requester; requester i uses bits [i*DW +: DW]
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  $clog2(NREQ)  originating requester
- rsp_data  out  DW  result block
- rsp_err  out  1  block aborted by timeout
- key_ready  in  1  key expansion complete for the current key length
- cu_cf  in  1  core input-ready flag
- cu_dout  in  DW  core state output
- cu_kf  out  1  key-ready flag to core
- cu_enc_dec  out  1  direction to core
- cu_din  out  DW  input block to core
- cu_clr  out  1  synchronous clear to core, active-high

## Operation
- FSM states:
  - IDLE: wait for a request.
  - RUN: wait for the core to finish.
  - RESP: hold the result until consumed.
- IDLE, grant condition: cu_cf & key_ready & |req_valid.
  - On grant, in the same cycle: winner = first valid index at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[winner] = 1.
  - cu_din = req_data[winner] and cu_enc_dec = req_enc_dec[winner]; both are combinational on the grant cycle and registered after it.
  - cu_kf = 1.
  - Latch the winner's ID; set rr_ptr = winner+1 mod NREQ; go to RUN.
- IDLE, no grant: cu_kf = 0, so the core falls back to its reset state and does not start on stale data.
- RUN:
  - cu_kf = key_ready; cu_enc_dec is held.
  - The first cycle with cu_cf = 1 is completion: capture cu_dout into rsp_data, rsp_err = 0, go to RESP.
- RESP:
  - rsp_valid = 1; cu_kf = 0; no grants.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Simultaneous events:
  - A new request while in RESP waits.
  - key_ready falling during RUN does not abort the block.
  - A req_valid dropped before acceptance is ignored.
- Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, cu_kf 0, cu_enc_dec 0, cu_din 0, cu_clr 1, rr_ptr 0, state IDLE.
  - cu_clr deasserts on the first CLK edge after CLR_N rises.
- Reset mid-RUN or mid-RESP: the in-flight block and its result are discarded; no response is produced.

## Timing
- Grant to core launch: 0 cycles (same-cycle handshake on cu_cf).
- Core-done to rsp_valid: 1 cycle (registered capture).
- Fastest re-grant: 1 cycle after the response handshake.
- At most one block in flight. Throughput = one block per (core latency + 2 + response wait).

## Configuration
- AES_ARB_TIMEOUT_EN defined:
  - A counter runs in RUN, cleared on grant.
  - When it reaches TO_CYCLES without cu_cf: pulse cu_clr for 1 cycle, rsp_data = 0, rsp_err = 1, go to RESP.
- AES_ARB_TIMEOUT_EN undefined:
  - No counter; rsp_err is tied 0.
  - RUN waits indefinitely.
  - cu_clr is asserted only during reset.

## Structure
- Package aes_arb_pkg holds:
  - the state enum typedef (IDLE, RUN, RESP);
  - the default NREQ and DW;
  - the ID-width function;
  - the default TO_CYCLES.
- Sub-module rr_pick: combinational round-robin picker with inputs valid vector and pointer, and outputs one-hot grant and index.

## Test plan
- Encrypt: requester 2, key 000102…0f (128-bit), pt 00112233445566778899aabbccddeeff -> one req_ready[2] pulse; rsp_id = 2; rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a; rsp_err = 0.
- Decrypt: requester 0, ct 69c4e0d8…c55a -> rsp_data = 00112233445566778899aabbccddeeff.
- Fairness: all four req_valid held continuously -> grant order 0, 1, 2, 3, 0, each requester accepted exactly once per four grants.
- Backpressure: rsp_ready low for 20 cycles -> rsp_valid, rsp_id and rsp_data stable; cu_kf = 0; no req_ready pulses.
- Reset mid-RUN: CLR_N low for 3 cycles -> all outputs go to reset values asynchronously; no response; after release the first grant goes to the lowest valid index.
- Timeout (macro on): stub core holds cu_cf = 0 after grant -> cu_clr pulses at cycle TO_CYCLES after the grant; rsp_err = 1 and rsp_data = 0 one cycle later.

Source files
------------

// File: rtl/aes_req_arbiter_pkg.sv
// Shared types and defaults for the AES request arbiter.
// Optional run timeout is enabled by defining AES_ARB_TIMEOUT_EN.
package aes_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 128;
  localparam int TO_CYCLES_DEF = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Requester ID width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Requester, response and cipher-core boundary signals of the AES arbiter.
// slave = arbiter side, master = requesters/core side.
interface aes_arb_if
  import aes_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);
  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_enc_dec;
  logic [NREQ*DW-1:0] req_data;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;

  logic               key_ready;
  logic               cu_cf;
  logic [DW-1:0]      cu_dout;
  logic               cu_kf;
  logic               cu_enc_dec;
  logic [DW-1:0]      cu_din;
  logic               cu_clr;

  modport slave (
    input  req_valid, req_enc_dec, req_data, rsp_ready, key_ready, cu_cf, cu_dout,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, cu_kf, cu_enc_dec, cu_din, cu_clr
  );

  modport master (
    output req_valid, req_enc_dec, req_data, rsp_ready, key_ready, cu_cf, cu_dout,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, cu_kf, cu_enc_dec, cu_din, cu_clr
  );

endinterface

// File: rtl/aes_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i,
// wrapping modulo NREQ; returns it both one-hot and encoded.
module rr_pick
  import aes_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid_i[wrap_add(int'(ptr_i), k, NREQ)]) begin
        found = 1'b1;
        gnt_o[wrap_add(int'(ptr_i), k, NREQ)] = 1'b1;
        idx_o = IDW'(wrap_add(int'(ptr_i), k, NREQ));
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between NREQ requesters, one block in flight at a time.
// Define AES_ARB_TIMEOUT_EN to abort blocks whose core run exceeds TO_CYCLES.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  aes_arb_if.slave bus
);

  localparam int IDW = id_w(NREQ);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic [DW-1:0]  din_q, din_d;
  logic           enc_q, enc_d;
  logic           err_q, err_d;
  logic           clr_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            grant;
  logic            timeout_hit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  // No grants while the core is still being cleared out of reset.
  assign grant = (state_q == IDLE) && !clr_q && bus.cu_cf && bus.key_ready && (|bus.req_valid);

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (grant) begin
      to_cnt_d = '0;
    end else if (state_q == RUN && !bus.cu_cf) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == RUN) && !bus.cu_cf && (to_cnt_q == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    rsp_data_d     = rsp_data_q;
    err_d          = err_q;
    din_d          = din_q;
    enc_d          = enc_q;
    bus.req_ready  = '0;
    bus.rsp_valid  = 1'b0;
    bus.cu_kf      = 1'b0;
    bus.cu_din     = din_q;
    bus.cu_enc_dec = enc_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          bus.req_ready  = pick_gnt;
          bus.cu_kf      = 1'b1;
          bus.cu_din     = bus.req_data[int'(pick_idx)*DW +: DW];
          bus.cu_enc_dec = bus.req_enc_dec[pick_idx];
          din_d          = bus.req_data[int'(pick_idx)*DW +: DW];
          enc_d          = bus.req_enc_dec[pick_idx];
          id_d           = pick_idx;
          rr_ptr_d       = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d        = RUN;
        end
      end
      RUN: begin
        // key_ready may drop mid-block; the block still runs to completion.
        bus.cu_kf = bus.key_ready;
        if (bus.cu_cf) begin
          rsp_data_d = bus.cu_dout;
          err_d      = 1'b0;
          state_d    = RESP;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      din_q      <= '0;
      enc_q      <= 1'b0;
      clr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      din_q      <= din_d;
      enc_q      <= enc_d;
      clr_q      <= 1'b0;
    end
  end

  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = err_q;
  assign bus.cu_clr   = clr_q | timeout_hit;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter; the bench itself plays the AES core.
// Timeout steps run only when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_req_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 128;
  localparam int TO_CYCLES = 31;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [127:0] dat [NREQ];
  logic [3:0]   enc;

  aes_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  aes_req_arbiter #(.NREQ(NREQ), .DW(DW), .TO_CYCLES(TO_CYCLES)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*DW +: DW] = dat[i];
      bus.req_enc_dec[i]       = enc[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full block: grant, core run of lat cycles, response held bp cycles.
  task automatic do_block(input logic [3:0] mask, input int exp_id, input logic [127:0] result,
                          input int lat, input int bp, input bit hold, input bit kr_drop);
    logic [3:0]   exp_rdy;
    logic [127:0] exp_din;
    logic         exp_enc;
    logic [3:0]   saved;
    bit           ok;
    exp_rdy = 4'b0001 << exp_id;
    exp_din = dat[exp_id];
    exp_enc = enc[exp_id];
    bus.req_valid = mask;
    #1;
    chk("grant_ready", bus.req_ready, exp_rdy);
    chk("grant_kf", bus.cu_kf, 1'b1);
    chk("grant_din", bus.cu_din, exp_din);
    chk("grant_dir", bus.cu_enc_dec, exp_enc);
    tick();
    if (!hold) begin
      bus.req_valid[exp_id] = 1'b0;
      bus.req_data[exp_id*DW +: DW] = ~exp_din;
      bus.req_enc_dec[exp_id] = ~exp_enc;
    end
    bus.cu_cf = 1'b0;
    #1;
    chk("run_ready", bus.req_ready, 4'b0000);
    chk("run_din_held", bus.cu_din, exp_din);
    chk("run_dir_held", bus.cu_enc_dec, exp_enc);
    chk("run_clr", bus.cu_clr, 1'b0);
    for (int c = 0; c < lat; c++) begin
      if (kr_drop && c == 0) begin
        bus.key_ready = 1'b0;
        #1;
        chk("run_kf_follows_key", bus.cu_kf, 1'b0);
      end
      tick();
      bus.key_ready = 1'b1;
    end
    bus.cu_dout = result;
    bus.cu_cf   = 1'b1;
    tick();
    bus.cu_dout = '0;
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_id", bus.rsp_id, exp_id[1:0]);
    chk("rsp_data", bus.rsp_data, result);
    chk("rsp_err", bus.rsp_err, 1'b0);
    chk("rsp_kf", bus.cu_kf, 1'b0);
    if (bp > 0) begin
      saved = bus.req_valid;
      bus.req_valid = 4'b1111;
      ok = 1'b1;
      for (int c = 0; c < bp; c++) begin
        tick();
        ok = ok && bus.rsp_valid === 1'b1 && bus.rsp_id === exp_id[1:0] && bus.rsp_data === result &&
             bus.cu_kf === 1'b0 && bus.req_ready === 4'b0000;
      end
      chk("backpressure_stable", ok, 1'b1);
      bus.req_valid = saved;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 1'b0);
    $display("[TB] block id=%0d dir=%0d din=%h rsp=%h", exp_id, exp_enc, exp_din, result);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req_valid   = 4'b0001;
    bus.req_data    = '0;
    bus.req_enc_dec = '0;
    bus.rsp_ready   = 1'b0;
    bus.key_ready   = 1'b1;
    bus.cu_cf       = 1'b1;
    bus.cu_dout     = '0;
    for (int i = 0; i < NREQ; i++) dat[i] = {4{32'h1000_0000 + i}};
    enc = 4'b1010;
    drive_reqs();

    #23;
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 2'd0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_kf", bus.cu_kf, 1'b0);
    chk("rst_dir", bus.cu_enc_dec, 1'b0);
    chk("rst_din", bus.cu_din, '0);
    chk("rst_clr", bus.cu_clr, 1'b1);
    bus.req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("clr_release", bus.cu_clr, 1'b0);
    $display("[TB] reset released");

    // No grant without key_ready; a request withdrawn before acceptance vanishes.
    bus.key_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    chk("nokey_ready", bus.req_ready, 4'b0000);
    chk("nokey_kf", bus.cu_kf, 1'b0);
    tick();
    bus.req_valid = 4'b0000;
    bus.key_ready = 1'b1;
    tick();
    chk("dropped_req_idle", bus.cu_kf, 1'b0);

    // Fairness: all requesters held valid.
    do_block(4'b1111, 0, 128'hA0, 2, 0, 1'b1, 1'b0);
    do_block(4'b1111, 1, 128'hA1, 1, 0, 1'b1, 1'b0);
    do_block(4'b1111, 2, 128'hA2, 3, 0, 1'b1, 1'b0);
    do_block(4'b1111, 3, 128'hA3, 0, 0, 1'b1, 1'b0);
    do_block(4'b1111, 0, 128'hA4, 1, 0, 1'b1, 1'b0);
    bus.req_valid = 4'b0000;

    // Encrypt from requester 2 with key_ready dropping mid-run.
    dat[2] = PT;
    enc[2] = 1'b1;
    drive_reqs();
    do_block(4'b0100, 2, CT, 4, 0, 1'b0, 1'b1);

    // Decrypt from requester 0 with 20 cycles of backpressure (rr_ptr is 3 here).
    dat[0] = CT;
    enc[0] = 1'b0;
    drive_reqs();
    do_block(4'b0001, 0, PT, 3, 20, 1'b0, 1'b0);

    // Reset in the middle of a run.
    dat[1] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    enc[1] = 1'b1;
    drive_reqs();
    bus.req_valid = 4'b0010;
    #1;
    chk("mid_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b0000;
    bus.cu_cf = 1'b0;
    tick();
    chk("mid_run_kf", bus.cu_kf, 1'b1);
    chk("mid_run_dir", bus.cu_enc_dec, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_kf", bus.cu_kf, 1'b0);
    chk("mid_rst_din", bus.cu_din, '0);
    chk("mid_rst_dir", bus.cu_enc_dec, 1'b0);
    chk("mid_rst_clr", bus.cu_clr, 1'b1);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    bus.cu_cf = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    chk("mid_clr_release", bus.cu_clr, 1'b0);
    chk("mid_no_rsp2", bus.rsp_valid, 1'b0);
    $display("[TB] reset mid-run, block discarded");
    drive_reqs();
    do_block(4'b1010, 1, 128'h55, 2, 0, 1'b0, 1'b0);
    do_block(4'b1000, 3, 128'h66, 1, 0, 1'b0, 1'b0);

`ifdef AES_ARB_TIMEOUT_EN
    begin
      bit quiet;
      bus.req_valid = 4'b0001;
      #1;
      chk("to_grant", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = 4'b0000;
      bus.cu_cf = 1'b0;
      quiet = 1'b1;
      for (int k = 1; k < TO_CYCLES; k++) begin
        #1;
        quiet = quiet && bus.cu_clr === 1'b0 && bus.rsp_valid === 1'b0;
        tick();
      end
      chk("to_quiet", quiet, 1'b1);
      chk("to_clr_pulse", bus.cu_clr, 1'b1);
      tick();
      chk("to_clr_done", bus.cu_clr, 1'b0);
      chk("to_rsp_valid", bus.rsp_valid, 1'b1);
      chk("to_rsp_err", bus.rsp_err, 1'b1);
      chk("to_rsp_data", bus.rsp_data, '0);
      bus.cu_cf = 1'b1;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      $display("[TB] timeout block id=0 err=1");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
